noc_inject_arbiter: RTL and testbench

NOC_INJECT_ARBITER -- requirements
Module: noc_inject_arbiter

---
 rtl/noc_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/noc_inject_arbiter.sv | 176 +++++++++++++++++
 tb/tb_noc_inject_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// ----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC injection arbiter:
//   arb_state_e   - arbiter FSM states (IDLE / LOCKED)
//   credit_width  - width of a credit counter that must hold 0..depth
//   idx_width     - width of a requester index (at least 1 bit)
// ----------------------------------------------------------------------------
package noc_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // The counter must represent the full depth itself, hence depth+1 values.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Keeps single-requester builds legal (no zero-width index vectors).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin winner selection. The search starts at
// (last_grant + 1) mod NUM_REQ and wraps upward.
// Ports:
//   req        in   NUM_REQ  request vector
//   last_grant in   IDX_W    index that won most recently
//   grant_idx  out  IDX_W    winning index (0 when no request)
//   any_req    out  1        at least one request is present
// ----------------------------------------------------------------------------
module rr_arbiter
    import noc_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise synthesis infers a latch.
        grant_idx = '0;
        any_req   = 1'b0;
        // Walk from the farthest offset to the nearest so the requester closest
        // after last_grant overwrites all others and wins.
        for (int off = NUM_REQ; off >= 1; off--) begin
            int idx;
            idx = (int'(last_grant) + off) % NUM_REQ;
            if (req[idx]) begin
                grant_idx = IDX_W'(idx);
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_inject_arbiter.sv
// ----------------------------------------------------------------------------
// noc_inject_arbiter
// Shares one router injection port among NUM_REQ AXI-Stream requesters.
// A requester is granted for a whole packet (until tlast); flits are only
// accepted while the downstream buffer has credits.
// Ports:
//   clk_noc       in   1                    clock
//   rst_noc_sync  in   1                    synchronous active-high reset
//   req_tvalid    in   NUM_REQ              per-requester valid
//   req_tready    out  NUM_REQ              per-requester ready (combinational)
//   req_tdata     in   NUM_REQ*FLIT_WIDTH   per-requester flit, requester i at slice i
//   req_tlast     in   NUM_REQ              last flit of packet
//   req_tdest     in   NUM_REQ*DEST_WIDTH   per-requester destination
//   data_out      out  FLIT_WIDTH           injected flit
//   dest_out      out  DEST_WIDTH           injected destination
//   is_tail_out   out  1                    injected flit is the packet tail
//   send_out      out  1                    injection strobe
//   credit_in     in   1                    one downstream credit returned
//   grant_idx     out  IDX_W                current or last grantee
//   busy          out  1                    arbiter is locked to a packet
// ----------------------------------------------------------------------------
module noc_inject_arbiter
    import noc_pkg::*;
#(
    parameter  int NUM_REQ           = 4,
    parameter  int FLIT_WIDTH        = 64,
    parameter  int DEST_WIDTH        = 6,
    parameter  int FLIT_BUFFER_DEPTH = 2,
    localparam int IDX_W             = idx_width(NUM_REQ)
) (
    input  logic                           clk_noc,
    input  logic                           rst_noc_sync,
    input  logic [NUM_REQ-1:0]             req_tvalid,
    output logic [NUM_REQ-1:0]             req_tready,
    input  logic [NUM_REQ*FLIT_WIDTH-1:0]  req_tdata,
    input  logic [NUM_REQ-1:0]             req_tlast,
    input  logic [NUM_REQ*DEST_WIDTH-1:0]  req_tdest,
    output logic [FLIT_WIDTH-1:0]          data_out,
    output logic [DEST_WIDTH-1:0]          dest_out,
    output logic                           is_tail_out,
    output logic                           send_out,
    input  logic                           credit_in,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           busy
);

    localparam int                CRED_W     = credit_width(FLIT_BUFFER_DEPTH);
    localparam logic [CRED_W-1:0] CRED_MAX   = CRED_W'(FLIT_BUFFER_DEPTH);
    localparam logic [CRED_W-1:0] CRED_ONE   = CRED_W'(1);
    // Last grant of NUM_REQ-1 makes the first search after reset start at 0.
    localparam logic [IDX_W-1:0]  LAST_RESET = IDX_W'(NUM_REQ - 1);

    arb_state_e              r_state;
    arb_state_e              w_state_next;
    logic [CRED_W-1:0]       r_credits;
    logic [IDX_W-1:0]        r_grant_idx;
    logic [IDX_W-1:0]        r_last_grant;
    logic [IDX_W-1:0]        w_arb_idx;
    logic                    w_any_req;
    logic                    w_has_credit;
    logic                    w_accept;
    logic [FLIT_WIDTH-1:0]   r_data;
    logic [DEST_WIDTH-1:0]   r_dest;
    logic                    r_tail;
    logic                    r_send;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_tvalid),
        .last_grant (r_last_grant),
        .grant_idx  (w_arb_idx),
        .any_req    (w_any_req)
    );

    assign w_has_credit = (r_credits != '0);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_noc) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst_noc_sync) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, ready and accept
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        req_tready   = '0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // Ready is withheld at zero credits, so the counter can never
                // underflow.
                req_tready[r_grant_idx] = w_has_credit;
                w_accept                = w_has_credit & req_tvalid[r_grant_idx];
                if (w_accept && req_tlast[r_grant_idx]) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Grant bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_grant_idx  <= '0;
            r_last_grant <= LAST_RESET;
        end else begin
            if (r_state == ST_IDLE && w_any_req) begin
                r_grant_idx <= w_arb_idx;
            end
            if (w_accept && req_tlast[r_grant_idx]) begin
                r_last_grant <= r_grant_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Credit counter: accept consumes, credit_in returns, both cancel out.
    // Credits beyond the buffer depth are dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_credits <= CRED_MAX;
        end else begin
            case ({w_accept, credit_in})
                2'b10: r_credits <= r_credits - CRED_ONE;
                2'b01: if (r_credits != CRED_MAX) r_credits <= r_credits + CRED_ONE;
                default: r_credits <= r_credits;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Injection flit register: loads on accept, holds otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_send <= 1'b0;
            r_tail <= 1'b0;
            r_data <= '0;
            r_dest <= '0;
        end else begin
            r_send <= w_accept;
            if (w_accept) begin
                r_data <= req_tdata[int'(r_grant_idx) * FLIT_WIDTH +: FLIT_WIDTH];
                r_dest <= req_tdest[int'(r_grant_idx) * DEST_WIDTH +: DEST_WIDTH];
                r_tail <= req_tlast[r_grant_idx];
            end
        end
    end

    assign send_out    = r_send;
    assign is_tail_out = r_tail;
    assign data_out    = r_data;
    assign dest_out    = r_dest;
    assign grant_idx   = r_grant_idx;
    assign busy        = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// ----------------------------------------------------------------------------
// tb_noc_inject_arbiter
// Self-checking bench for noc_inject_arbiter: a vector table for round-robin
// order, hand sequences for the multi-cycle corner cases, and a randomized
// phase, all compared against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_noc_inject_arbiter;

    localparam int NR    = 4;
    localparam int FW    = 64;
    localparam int DW    = 6;
    localparam int DEPTH = 2;

    logic               clk_noc;
    logic               rst_noc_sync;
    logic [NR-1:0]      req_tvalid;
    logic [NR-1:0]      req_tready;
    logic [NR*FW-1:0]   req_tdata;
    logic [NR-1:0]      req_tlast;
    logic [NR*DW-1:0]   req_tdest;
    logic [FW-1:0]      data_out;
    logic [DW-1:0]      dest_out;
    logic               is_tail_out;
    logic               send_out;
    logic               credit_in;
    logic [1:0]         grant_idx;
    logic               busy;

    noc_inject_arbiter #(
        .NUM_REQ           (NR),
        .FLIT_WIDTH        (FW),
        .DEST_WIDTH        (DW),
        .FLIT_BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk_noc      (clk_noc),
        .rst_noc_sync (rst_noc_sync),
        .req_tvalid   (req_tvalid),
        .req_tready   (req_tready),
        .req_tdata    (req_tdata),
        .req_tlast    (req_tlast),
        .req_tdest    (req_tdest),
        .data_out     (data_out),
        .dest_out     (dest_out),
        .is_tail_out  (is_tail_out),
        .send_out     (send_out),
        .credit_in    (credit_in),
        .grant_idx    (grant_idx),
        .busy         (busy)
    );

    initial begin
        clk_noc = 1'b0;
        forever #5 clk_noc = ~clk_noc;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who owns the port, how many buffer slots are free,
    // and what the last injected flit looked like.
    // ------------------------------------------------------------------
    bit            m_locked;
    int            m_owner;
    int            m_last;
    int            m_credits;
    bit            m_send;
    bit            m_tail;
    logic [FW-1:0] m_data;
    logic [DW-1:0] m_dest;

    function automatic logic [NR-1:0] model_tready();
        logic [NR-1:0] t;
        t = '0;
        if (m_locked && m_credits > 0) t[m_owner] = 1'b1;
        return t;
    endfunction

    task automatic model_step(input logic [NR-1:0] v, input logic [NR-1:0] l,
                              input logic c, input logic r);
        bit acc;
        bit found;
        int nc;
        if (r) begin
            m_locked = 0; m_owner = 0; m_last = NR - 1; m_credits = DEPTH;
            m_send = 0; m_tail = 0; m_data = '0; m_dest = '0;
        end else begin
            acc = m_locked && (m_credits > 0) && v[m_owner];
            nc  = m_credits + int'(c) - int'(acc);
            if (nc > DEPTH) nc = DEPTH;
            m_send = acc;
            if (acc) begin
                m_data = req_tdata[m_owner*FW +: FW];
                m_dest = req_tdest[m_owner*DW +: DW];
                m_tail = l[m_owner];
            end
            if (!m_locked) begin
                found = 0;
                for (int k = 1; k <= NR; k++) begin
                    if (!found && v[(m_last + k) % NR]) begin
                        m_owner  = (m_last + k) % NR;
                        m_locked = 1;
                        found    = 1;
                    end
                end
            end else if (acc && l[m_owner]) begin
                m_locked = 0;
                m_last   = m_owner;
            end
            m_credits = nc;
        end
    endtask

    // One clock: drive, check ready before the edge, advance model, check
    // registered outputs one time unit after the edge.
    task automatic cycle(input logic [NR-1:0] v, input logic [NR-1:0] l,
                         input logic c, input logic r, output logic [NR-1:0] tr);
        req_tvalid   = v;
        req_tlast    = l;
        credit_in    = c;
        rst_noc_sync = r;
        #1;
        tr = req_tready;
        check("model_tready", 64'(tr), 64'(model_tready()));
        model_step(v, l, c, r);
        @(posedge clk_noc);
        #1;
        check("model_send_out", 64'(send_out), 64'(m_send));
        check("model_is_tail_out", 64'(is_tail_out), 64'(m_tail));
        check("model_data_out", data_out, m_data);
        check("model_dest_out", 64'(dest_out), 64'(m_dest));
        check("model_grant_idx", 64'(grant_idx), 64'(m_owner));
        check("model_busy", 64'(busy), 64'(m_locked));
    endtask

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] exp_tready;
        logic          exp_send;
        logic [1:0]    exp_grant;
        logic          exp_busy;
        logic          exp_tail;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [NR-1:0] tr;
        logic [NR-1:0] v;
        logic [NR-1:0] l;
        bit            sched[0:15];
        int            sends;
        int            acc;
        int            first_send;
        int            tail_at;
        int            run;

        // Fixed payloads: flit i = 0x0123_4567_0000_00Di, dest i = 8+i.
        for (int i = 0; i < NR; i++) begin
            req_tdata[i*FW +: FW] = 64'h0123_4567_0000_00D0 | 64'(i);
            req_tdest[i*DW +: DW] = DW'(8 + i);
        end
        req_tvalid = '0; req_tlast = '0; credit_in = 1'b0; rst_noc_sync = 1'b1;
        model_step('0, '0, 1'b0, 1'b1);
        repeat (2) @(posedge clk_noc);
        #1;

        // Reset state
        check("rst_grant_idx", 64'(grant_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_send_out", 64'(send_out), 64'd0);
        check("rst_is_tail_out", 64'(is_tail_out), 64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_dest_out", 64'(dest_out), 64'd0);
        check("rst_tready", 64'(req_tready), 64'd0);

        // Round-robin order with all four requesters sending 1-flit packets.
        vecs[0] = '{4'hF, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[1] = '{4'hF, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1};
        vecs[2] = '{4'hF, 4'h0, 1'b0, 2'd1, 1'b1, 1'b1};
        vecs[3] = '{4'hF, 4'h2, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[4] = '{4'hF, 4'h0, 1'b0, 2'd2, 1'b1, 1'b1};
        vecs[5] = '{4'hF, 4'h4, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[6] = '{4'hF, 4'h0, 1'b0, 2'd3, 1'b1, 1'b1};
        vecs[7] = '{4'hF, 4'h8, 1'b1, 2'd3, 1'b0, 1'b1};
        vecs[8] = '{4'hF, 4'h0, 1'b0, 2'd0, 1'b1, 1'b1};
        vecs[9] = '{4'hF, 4'h1, 1'b1, 2'd0, 1'b0, 1'b1};
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].valid, 4'hF, 1'b1, 1'b0, tr);
            check("rr_tready", 64'(tr), 64'(vecs[i].exp_tready));
            check("rr_send_out", 64'(send_out), 64'(vecs[i].exp_send));
            check("rr_grant_idx", 64'(grant_idx), 64'(vecs[i].exp_grant));
            check("rr_busy", 64'(busy), 64'(vecs[i].exp_busy));
            check("rr_is_tail_out", 64'(is_tail_out), 64'(vecs[i].exp_tail));
            if (vecs[i].exp_send) check("rr_dest_out", 64'(dest_out), 64'(8 + vecs[i].exp_grant));
        end

        // Requester 1, 3-flit packet, credit returned 2 cycles after each send.
        cycle('0, '0, 1'b0, 1'b1, tr);
        for (int k = 0; k < 16; k++) sched[k] = 0;
        acc = 0; sends = 0; first_send = -1; tail_at = -1;
        for (int k = 0; k < 12; k++) begin
            v = (acc < 3) ? 4'b0010 : 4'b0000;
            l = (acc == 2) ? 4'b0010 : 4'b0000;
            cycle(v, l, sched[k], 1'b0, tr);
            if (tr[1] && v[1]) acc++;
            if (send_out) begin
                sends++;
                if (first_send < 0) first_send = k;
                if (is_tail_out) tail_at = sends;
                check("pkt3_dest_out", 64'(dest_out), 64'd9);
                if (k + 2 < 16) sched[k + 2] = 1;
            end
        end
        check("pkt3_first_send_cycle", 64'(first_send), 64'd1);
        check("pkt3_sends", 64'(sends), 64'd3);
        check("pkt3_tail_position", 64'(tail_at), 64'd3);

        // Credit exhaustion: 4-flit packet, no credit_in.
        cycle('0, '0, 1'b0, 1'b1, tr);
        acc = 0; sends = 0;
        for (int k = 0; k < 7; k++) begin
            v = (acc < 4) ? 4'b0001 : 4'b0000;
            l = (acc == 3) ? 4'b0001 : 4'b0000;
            cycle(v, l, 1'b0, 1'b0, tr);
            if (tr[0] && v[0]) acc++;
            if (send_out) sends++;
        end
        check("nocred_sends", 64'(sends), 64'd2);
        check("nocred_tready", 64'(tr), 64'd0);
        cycle(4'b0001, 4'b0000, 1'b1, 1'b0, tr);
        for (int k = 0; k < 5; k++) begin
            cycle(4'b0001, 4'b0000, 1'b0, 1'b0, tr);
            if (send_out) sends++;
        end
        check("onecred_sends", 64'(sends), 64'd3);

        // Accept and credit_in together at credits=1: stream never stalls.
        cycle('0, '0, 1'b0, 1'b1, tr);
        cycle(4'b0001, 4'b0000, 1'b0, 1'b0, tr);
        run = 0;
        for (int j = 0; j < 5; j++) begin
            cycle(4'b0001, (j == 4) ? 4'b0001 : 4'b0000, (j > 0), 1'b0, tr);
            check("samecyc_tready", 64'(tr), 64'h1);
            if (send_out) run++;
        end
        check("samecyc_run", 64'(run), 64'd5);

        // Requester 2 stalls mid-packet while requester 0 waits.
        cycle('0, '0, 1'b0, 1'b1, tr);
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0, tr);
        cycle(4'b0100, 4'b0000, 1'b1, 1'b0, tr);
        for (int k = 0; k < 3; k++) begin
            cycle(4'b0001, 4'b0000, 1'b1, 1'b0, tr);
            check("stall_grant_idx", 64'(grant_idx), 64'd2);
            check("stall_send_out", 64'(send_out), 64'd0);
            check("stall_busy", 64'(busy), 64'd1);
        end
        cycle(4'b0101, 4'b0100, 1'b1, 1'b0, tr);
        check("stall_tail_send", 64'(send_out), 64'd1);
        check("stall_tail", 64'(is_tail_out), 64'd1);
        check("stall_tail_dest", 64'(dest_out), 64'd10);
        check("stall_tail_grant", 64'(grant_idx), 64'd2);

        // Reset mid-packet.
        cycle('0, '0, 1'b0, 1'b1, tr);
        cycle(4'b1000, 4'b0000, 1'b0, 1'b0, tr);
        cycle(4'b1000, 4'b0000, 1'b0, 1'b0, tr);
        cycle(4'b1011, 4'b0000, 1'b0, 1'b1, tr);
        check("midrst_grant_idx", 64'(grant_idx), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_send_out", 64'(send_out), 64'd0);
        check("midrst_is_tail_out", 64'(is_tail_out), 64'd0);
        check("midrst_data_out", data_out, 64'd0);
        check("midrst_dest_out", 64'(dest_out), 64'd0);
        check("midrst_tready", 64'(req_tready), 64'd0);
        cycle(4'b1010, 4'b0000, 1'b0, 1'b0, tr);
        check("midrst_next_grant", 64'(grant_idx), 64'd1);
        sends = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(4'b1010, 4'b0000, 1'b0, 1'b0, tr);
            if (send_out) sends++;
        end
        check("midrst_credits_restored", 64'(sends), 64'd2);

        // Randomized traffic against the model.
        cycle('0, '0, 1'b0, 1'b1, tr);
        for (int n = 0; n < 600; n++) begin
            for (int w = 0; w < NR * FW / 32; w++) req_tdata[w*32 +: 32] = $urandom;
            for (int i = 0; i < NR; i++) req_tdest[i*DW +: DW] = DW'($urandom);
            v = NR'($urandom);
            for (int i = 0; i < NR; i++) l[i] = ($urandom_range(0, 2) == 0);
            cycle(v, l, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0), tr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
